// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
//
// Command buffer and issue stage in front of a 4-bit combinational ALU
// (behavioral_alu). Commands arrive over a valid/ready handshake and wait in a
// small FIFO. The FIFO head drives the ALU inputs combinationally. The ALU
// response is captured into a result register with its own valid/ready
// handshake. Results leave in command order at up to one per cycle.
//
// Optional feature macro: ALU_ISSUE_ACC_EN
//   When defined, a 4-bit accumulator loads the ALU result on every issue.
//   Commands tagged with cmd_acc then take operand a from the accumulator.
//   When undefined, cmd_acc is ignored and no accumulator exists.
//
// Parameters
//   DEPTH          command FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   cmd_valid      command present
//   cmd_ready      FIFO can accept (= !full)
//   cmd_op         ALU opcode: ADD SUB AND OR XOR NOT SHL SHR
//   cmd_a, cmd_b   operands
//   cmd_acc        take operand a from the accumulator (feature macro only)
//   alu_a, alu_b   to the ALU operands (0 when the FIFO is empty)
//   alu_operation  to the ALU opcode  (ADD when the FIFO is empty)
//   alu_result     from the ALU result
//   alu_carry_out  from the ALU carry/borrow
//   res_valid      result register holds a result
//   res_ready      consumer accepts the result
//   res_data       registered ALU result
//   res_carry      registered carry/borrow
//   res_zero       registered (result == 0)
//   fifo_count     entries currently in the FIFO
// -----------------------------------------------------------------------------
module alu_issue_unit #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [3:0]                 cmd_a,
  input  logic [3:0]                 cmd_b,
  input  logic                       cmd_acc,
  output logic [3:0]                 alu_a,
  output logic [3:0]                 alu_b,
  output logic [2:0]                 alu_operation,
  input  logic [3:0]                 alu_result,
  input  logic                       alu_carry_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [3:0]                 res_data,
  output logic                       res_carry,
  output logic                       res_zero,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_issue_unit: DEPTH must be a power of two and at least 2");
  end

  // One stored command. The acc tag only exists when the accumulator does.
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
`ifdef ALU_ISSUE_ACC_EN
    logic       acc;
`endif
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          wr_entry;
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          issue;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  // The result register frees up when empty or being drained this edge.
  assign issue     = !empty && (!res_valid || res_ready);
  assign fifo_count = count;

  assign wr_entry.op = cmd_op;
  assign wr_entry.a  = cmd_a;
  assign wr_entry.b  = cmd_b;
`ifdef ALU_ISSUE_ACC_EN
  assign wr_entry.acc = cmd_acc;
`else
  // cmd_acc has no effect in this build.
  logic unused_acc;
  assign unused_acc = cmd_acc;
`endif

  // NOTE: The storage array has no reset. Stale entries are never observed
  // because the ALU drive is masked while the FIFO is empty, and leaving the
  // array out of the reset tree lets it map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  assign head = mem[rd_ptr];

  // NOTE: Sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      if (push && !issue) begin
        count <= count + CW'(1);
      end else if (!push && issue) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef ALU_ISSUE_ACC_EN
  logic [3:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (issue) begin
      acc_q <= alu_result;
    end
  end
`endif

  // NOTE: Every output of this block is defaulted first, so no path through
  // it leaves a value unassigned and no latch is inferred.
  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_operation = '0;
    if (!empty) begin
      alu_operation = head.op;
      alu_b         = head.b;
`ifdef ALU_ISSUE_ACC_EN
      alu_a         = head.acc ? acc_q : head.a;
`else
      alu_a         = head.a;
`endif
    end
  end

  // Result register: loads on issue, otherwise clears when drained and
  // holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
    end else if (issue) begin
      res_valid <= 1'b1;
      res_data  <= alu_result;
      res_carry <= alu_carry_out;
      res_zero  <= (alu_result == 4'd0);
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
